// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the burst-read memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_responder_pkg;

    // Controller states: IDLE accepts requests, READ issues burst reads.
    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } mem_resp_state_e;

    // Response buffer depth and the width of its occupancy count.
    localparam int RESP_FIFO_DEPTH = 4;
    localparam int RESP_FIFO_CNT_W = $clog2(RESP_FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_responder_resp_fifo.sv
// Response buffer: synchronous FIFO with first-word-fall-through output.
// Latency: a pushed word appears on dat_o the cycle after the push edge.
// Backpressure: head holds while pop_i is low; pushes into a full FIFO are ignored.
module resp_fifo
    import mem_responder_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = RESP_FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic                       vld_o,
    output logic [WIDTH-1:0]           dat_o,
    output logic [RESP_FIFO_CNT_W-1:0] cnt_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0]           mem_q [DEPTH];
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [RESP_FIFO_CNT_W-1:0] cnt_q;
    logic                       wr_en;
    logic                       rd_en;

    assign wr_en = push_i && (cnt_q != RESP_FIFO_CNT_W'(DEPTH));
    assign rd_en = pop_i && (cnt_q != '0);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + RESP_FIFO_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - RESP_FIFO_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents as valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign vld_o = (cnt_q != '0);
    assign dat_o = mem_q[rd_ptr_q];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_responder.sv
// On-chip word memory: single-word masked writes, fixed-length wrapping read bursts.
// Latency: first beat valid 2 cycles after the read handshake, then one beat per cycle.
// Backpressure: reads issue only while buffer plus in-flight reads leave room; resp_ready_i stalls the head.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_AW     = 12,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reader_valid_i,
    output logic                  reader_ready_o,
    input  logic [ADDR_WIDTH-1:0] reader_addr_i,
    input  logic                  writer_valid_i,
    output logic                  writer_ready_o,
    input  logic [ADDR_WIDTH-1:0] writer_addr_i,
    input  logic [DATA_WIDTH-1:0] writer_data_i,
    input  logic [1:0]            writer_dqm_i,
    output logic                  resp_valid_o,
    output logic                  resp_last_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    input  logic                  resp_ready_i,
    output logic                  busy_o,
    output logic                  error_oob_o
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int OCC_W = RESP_FIFO_CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    mem_resp_state_e             state_q;
    logic [MEM_AW-1:0]           rd_idx_q;
    logic [CNT_W-1:0]            issue_cnt_q;
    logic                        rd_zero_q;       // current burst is out of range
    logic                        rd_pend_q;       // a RAM read completes this cycle
    logic                        rd_pend_last_q;
    logic                        rd_pend_zero_q;
    logic                        err_q;
    logic [DATA_WIDTH-1:0]       ram_rd_q;
    logic [DATA_WIDTH-1:0]       ram_q [2**MEM_AW];

    logic                        rd_hs;
    logic                        wr_hs;
    logic                        rd_oob;
    logic                        wr_oob;
    logic                        issue;
    logic [OCC_W-1:0]            occ;
    logic                        fifo_vld;
    logic [DATA_WIDTH:0]         fifo_dat;
    logic [RESP_FIFO_CNT_W-1:0]  fifo_cnt;
    logic [DATA_WIDTH:0]         push_dat;

    assign reader_ready_o = (state_q == IDLE);
    assign writer_ready_o = (state_q == IDLE) && !reader_valid_i;
    assign rd_hs  = reader_valid_i && reader_ready_o;
    assign wr_hs  = writer_valid_i && writer_ready_o;
    assign rd_oob = |reader_addr_i[ADDR_WIDTH-1:MEM_AW];
    assign wr_oob = |writer_addr_i[ADDR_WIDTH-1:MEM_AW];

    // Count the read already in flight so its data always has a FIFO slot to land in.
    assign occ   = {1'b0, fifo_cnt} + OCC_W'(rd_pend_q);
    assign issue = (state_q == READ) && (occ < OCC_W'(RESP_FIFO_DEPTH));

    // Burst controller: latch start index on accept, issue reads, leave after the last issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rd_idx_q    <= '0;
            issue_cnt_q <= '0;
            rd_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_hs) begin
                        state_q     <= READ;
                        rd_idx_q    <= reader_addr_i[MEM_AW-1:0];
                        issue_cnt_q <= '0;
                        rd_zero_q   <= rd_oob;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_idx_q    <= rd_idx_q + MEM_AW'(1);
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                        if (issue_cnt_q == LAST_CNT) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags travelling alongside the one-cycle RAM read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            rd_pend_zero_q <= 1'b0;
        end else begin
            rd_pend_q      <= issue;
            rd_pend_last_q <= issue && (issue_cnt_q == LAST_CNT);
            rd_pend_zero_q <= rd_zero_q;
        end
    end

    // Sticky out-of-range flag; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if ((rd_hs && rd_oob) || (wr_hs && wr_oob)) begin
            err_q <= 1'b1;
        end
    end

    // Dual-port RAM with byte-masked writes and registered read; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_hs && !wr_oob) begin
            if (!writer_dqm_i[0]) ram_q[writer_addr_i[MEM_AW-1:0]][7:0] <= writer_data_i[7:0];
            if (!writer_dqm_i[1]) ram_q[writer_addr_i[MEM_AW-1:0]][DATA_WIDTH-1:8] <= writer_data_i[DATA_WIDTH-1:8];
        end
        if (issue) ram_rd_q <= ram_q[rd_idx_q];
    end

    assign push_dat = {rd_pend_last_q, (rd_pend_zero_q ? {DATA_WIDTH{1'b0}} : ram_rd_q)};

    resp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (rd_pend_q),
        .push_dat_i (push_dat),
        .pop_i      (resp_ready_i),
        .vld_o      (fifo_vld),
        .dat_o      (fifo_dat),
        .cnt_o      (fifo_cnt)
    );

    // Outputs read as zero whenever no beat is presented.
    assign resp_valid_o = fifo_vld;
    assign resp_last_o  = fifo_vld && fifo_dat[DATA_WIDTH];
    assign resp_data_o  = fifo_vld ? fifo_dat[DATA_WIDTH-1:0] : '0;
    assign busy_o       = (state_q != IDLE) || fifo_vld;
    assign error_oob_o  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a word-array and beat-queue reference model.
// Latency: checks first-beat timing, one-beat-per-cycle bursts and write deferral behind a burst.
// Backpressure: random resp_ready_i with stall-stability and beat-ordering checks.
module tb_mem_responder;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 8;
    localparam int NW = 4096;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          reader_valid_i = 1'b0;
    logic          reader_ready_o;
    logic [AW-1:0] reader_addr_i = '0;
    logic          writer_valid_i = 1'b0;
    logic          writer_ready_o;
    logic [AW-1:0] writer_addr_i = '0;
    logic [DW-1:0] writer_data_i = '0;
    logic [1:0]    writer_dqm_i = '0;
    logic          resp_valid_o;
    logic          resp_last_o;
    logic [DW-1:0] resp_data_o;
    logic          resp_ready_i = 1'b1;
    logic          busy_o;
    logic          error_oob_o;

    mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_AW     (12),
        .BURST_LEN  (BL)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reader_valid_i (reader_valid_i),
        .reader_ready_o (reader_ready_o),
        .reader_addr_i  (reader_addr_i),
        .writer_valid_i (writer_valid_i),
        .writer_ready_o (writer_ready_o),
        .writer_addr_i  (writer_addr_i),
        .writer_data_i  (writer_data_i),
        .writer_dqm_i   (writer_dqm_i),
        .resp_valid_o   (resp_valid_o),
        .resp_last_o    (resp_last_o),
        .resp_data_o    (resp_data_o),
        .resp_ready_i   (resp_ready_i),
        .busy_o         (busy_o),
        .error_oob_o    (error_oob_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: word array, sticky error flag, queue of expected beats.
    typedef struct {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    logic [DW-1:0] mem_m [NW];
    bit            exp_err = 1'b0;
    beat_t         exp_q[$];
    int            hs_edge = 0;
    int            beat_cnt = 0;
    int            obs_idx = 0;
    logic [DW-1:0] first_dat = '0;
    bit            rdy_rand = 1'b0;

    // Consumer: always ready, or a random mix of ready and stall.
    initial forever begin
        @(posedge clk_i);
        #1 resp_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scores beats, checks stall stability, and feeds the model on handshakes.
    initial begin
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_dat = '0;
        logic          prev_last = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 1'b0;
                obs_idx    = 0;
            end else begin
                chk("err_oob", error_oob_o, exp_err);
                if (prev_stall) begin
                    chk("stall_vld", resp_valid_o, 1);
                    chk("stall_dat", resp_data_o, prev_dat);
                    chk("stall_last", resp_last_o, prev_last);
                end
                if (resp_valid_o && resp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", resp_valid_o, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("beat_dat", resp_data_o, e.dat);
                        chk("beat_last", resp_last_o, e.last);
                    end
                    if (obs_idx == 0) first_dat = resp_data_o;
                    obs_idx = (obs_idx + 1) % BL;
                    beat_cnt++;
                end
                prev_stall = resp_valid_o && !resp_ready_i;
                prev_dat   = resp_data_o;
                prev_last  = resp_last_o;
                if (reader_valid_i && reader_ready_o) begin
                    bit oob;
                    hs_edge = cyc + 1;
                    oob = (reader_addr_i >= AW'(NW));
                    if (oob) exp_err = 1'b1;
                    for (int i = 0; i < BL; i++) begin
                        int a;
                        a = int'((reader_addr_i + AW'(i)) % AW'(NW));
                        exp_q.push_back('{dat: (oob ? '0 : mem_m[a]), last: (i == BL - 1)});
                    end
                end
                if (writer_valid_i && writer_ready_o) begin
                    if (writer_addr_i >= AW'(NW)) begin
                        exp_err = 1'b1;
                    end else begin
                        int a;
                        a = int'(writer_addr_i);
                        if (!writer_dqm_i[0]) mem_m[a][7:0]  = writer_data_i[7:0];
                        if (!writer_dqm_i[1]) mem_m[a][15:8] = writer_data_i[15:8];
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end #1 after a rising edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        writer_valid_i = 1'b1;
        writer_addr_i  = a;
        writer_data_i  = d;
        writer_dqm_i   = m;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (writer_ready_o) break;
        end
        chk("wr_accept", writer_ready_o, 1);
        @(posedge clk_i);
        #1 writer_valid_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        reader_valid_i = 1'b1;
        reader_addr_i  = a;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (reader_ready_o) break;
        end
        chk("rd_accept", reader_ready_o, 1);
        @(posedge clk_i);
        #1 reader_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !resp_valid_o) break;
        end
        chk("drain_q", exp_q.size(), 0);
        chk("drain_busy", busy_o, 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b0;
        int acc;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_vld", resp_valid_o, 0);
        chk("rst_last", resp_last_o, 0);
        chk("rst_data", resp_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", error_oob_o, 0);
        chk("rst_rd_rdy", reader_ready_o, 1);
        chk("rst_wr_rdy", writer_ready_o, 1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Known contents for every word any read below can touch.
        for (int a = 0; a < 64; a++) do_write(AW'(a), 16'h8000 | DW'(a), 2'b00);
        for (int a = NW - 16; a < NW; a++) do_write(AW'(a), 16'h4000 | DW'(a), 2'b00);

        // Full write then burst read: data, last position, first-beat latency.
        do_write(24'h10, 16'hA5A5, 2'b00);
        do_read(24'h10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (resp_valid_o) break;
        end
        chk("first_lat", cyc - hs_edge, 2);
        @(posedge clk_i);
        #1;
        wait_drain();
        chk("beat0_a5a5", first_dat, 16'hA5A5);

        // Byte mask keeps the low byte.
        do_write(24'h20, 16'hFFFF, 2'b00);
        do_write(24'h20, 16'h1234, 2'b01);
        do_read(24'h20);
        wait_drain();
        chk("beat0_masked", first_dat, 16'h12FF);

        // Burst wrapping past the top of memory.
        do_read(24'hFFC);
        wait_drain();
        chk("wrap_beat0", first_dat, 16'h4FFC);

        // Simultaneous read and write: read wins, write waits out the burst issue.
        reader_valid_i = 1'b1;
        reader_addr_i  = 24'h8;
        writer_valid_i = 1'b1;
        writer_addr_i  = 24'h30;
        writer_data_i  = 16'hBEEF;
        writer_dqm_i   = 2'b00;
        @(negedge clk_i);
        chk("both_rd_rdy", reader_ready_o, 1);
        chk("both_wr_rdy", writer_ready_o, 0);
        @(posedge clk_i);
        #1 reader_valid_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (writer_ready_o) break;
        end
        acc = cyc + 1;
        chk("wr_after_burst", acc - hs_edge, BL + 1);
        @(posedge clk_i);
        #1 writer_valid_i = 1'b0;
        wait_drain();
        do_read(24'h30);
        wait_drain();
        chk("beat0_beef", first_dat, 16'hBEEF);

        // Random mix of writes and back-to-back bursts under random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      do_write(AW'($urandom_range(0, 63)), DW'($urandom), 2'($urandom));
            else if (r < 8) do_read(AW'($urandom_range(0, 56)));
            else            do_read(AW'($urandom_range(NW - 8, NW - 1)));
        end
        wait_drain();
        rdy_rand = 1'b0;

        // Out-of-range burst returns zeros; reset mid-burst aborts it.
        do_read(24'h001000);
        chk("oob_rd_err", error_oob_o, 1);
        b0 = beat_cnt;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (beat_cnt >= b0 + 3) break;
        end
        chk("oob_beats_seen", beat_cnt - b0, 3);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("midrst_vld", resp_valid_o, 0);
        chk("midrst_err", error_oob_o, 0);
        chk("midrst_busy", busy_o, 0);
        exp_q.delete();
        exp_err = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("post_rst_vld", resp_valid_o, 0);

        // Out-of-range write is dropped; memory survived the reset.
        do_write(24'h001010, 16'h0BAD, 2'b00);
        chk("oob_wr_err", error_oob_o, 1);
        do_read(24'h10);
        wait_drain();
        chk("oob_wr_dropped", first_dat, mem_m[16]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
